// File: rtl/adder_result_collector.sv
// adder_result_collector: FIFO that collects {carry, sum} results from an upstream adder.
// Latency: a result pushed on edge k is visible on out_data/out_valid right after edge k; outputs depend on registers only.
// Backpressure: out_valid/out_ready handshake. When full, a push is accepted only if a pop happens in the same cycle; otherwise it is dropped and ovf is set.
//
// Ports:
//   clk, rst_n           - single clock, asynchronous active-low reset
//   in_valid/in_sum/in_carry - upstream adder result (no backpressure towards the adder)
//   out_valid/out_ready/out_data - head entry {carry, sum}; out_data is zero when empty
//   level                - number of entries held (0..DEPTH)
//   carry_cnt            - saturating count of accepted results with carry=1
//   ovf / ovf_clr        - sticky drop flag and its clear (a drop in the clear cycle wins)
//   out_parity           - XOR of out_data bits; only present when ADDER_RESULT_PARITY_EN is defined
module adder_result_collector #(
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [N-1:0]           in_sum,
  input  logic                   in_carry,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N:0]             out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             carry_cnt,
  output logic                   ovf,
  input  logic                   ovf_clr
`ifdef ADDER_RESULT_PARITY_EN
  ,
  output logic                   out_parity
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_ONE = 1;

  logic [N:0]  r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [AW:0] r_level;
  logic [7:0]  r_carry_cnt;
  logic        r_ovf;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_pop  = !w_empty && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still take the push.
  assign w_push = in_valid && (!w_full || w_pop);
  assign w_drop = in_valid && w_full && !w_pop;

  // Storage is not reset; entries are only reachable through the reset pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {in_carry, in_sum};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_carry_cnt <= '0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + LVL_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + LVL_ONE;
      end

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase

      if (w_push && in_carry && (r_carry_cnt != 8'hFF)) begin
        r_carry_cnt <= r_carry_cnt + 8'd1;
      end

      // Set has priority over clear so a drop in the clearing cycle is not lost.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign level     = r_level;
  assign carry_cnt = r_carry_cnt;
  assign ovf       = r_ovf;

`ifdef ADDER_RESULT_PARITY_EN
  assign out_parity = ^out_data;
`endif

endmodule

// File: tb/tb_adder_result_collector.sv
// Bench for adder_result_collector: table of directed single-cycle steps with
// hand-computed expectations, then a long streaming run and a mid-stream reset.
module tb_adder_result_collector;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_sum;
  logic       in_carry;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_data;
  logic [2:0] level;
  logic [7:0] carry_cnt;
  logic       ovf;
  logic       ovf_clr;
`ifdef ADDER_RESULT_PARITY_EN
  logic       out_parity;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  adder_result_collector #(.N(4), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sum    (in_sum),
    .in_carry  (in_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .carry_cnt (carry_cnt),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
`ifdef ADDER_RESULT_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic       iv;
    logic [3:0] sum;
    logic       ic;
    logic       rdy;
    logic       clr;
    logic       ev;
    logic [4:0] ed;
    logic [2:0] el;
    logic [7:0] ec;
    logic       eo;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(input logic iv, input logic [3:0] sum, input logic ic,
                              input logic rdy, input logic clr, input logic ev,
                              input logic [4:0] ed, input logic [2:0] el,
                              input logic [7:0] ec, input logic eo);
    vec_t v;
    v.iv = iv; v.sum = sum; v.ic = ic; v.rdy = rdy; v.clr = clr;
    v.ev = ev; v.ed = ed; v.el = el; v.ec = ec; v.eo = eo;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic [4:0] ed,
                            input logic [2:0] el, input logic [7:0] ec, input logic eo);
    check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ev});
    check({tag, ".out_data"},  {27'd0, out_data},  {27'd0, ed});
    check({tag, ".level"},     {29'd0, level},     {29'd0, el});
    check({tag, ".carry_cnt"}, {24'd0, carry_cnt}, {24'd0, ec});
    check({tag, ".ovf"},       {31'd0, ovf},       {31'd0, eo});
`ifdef ADDER_RESULT_PARITY_EN
    check({tag, ".out_parity"}, {31'd0, out_parity}, {31'd0, ^ed});
`endif
  endtask

  initial begin
    //                iv sum   ic rdy clr   ev data   lvl cnt  ovf
    vecs[0]  = mk(1, 4'hA, 1, 0, 0,   1, 5'h1A, 1, 8'd1, 0); // first push after reset
    vecs[1]  = mk(0, 4'h0, 0, 1, 0,   0, 5'h00, 0, 8'd1, 0); // pop to empty
    vecs[2]  = mk(1, 4'h3, 0, 0, 0,   1, 5'h03, 1, 8'd1, 0);
    vecs[3]  = mk(1, 4'h5, 0, 0, 0,   1, 5'h03, 2, 8'd1, 0);
    vecs[4]  = mk(1, 4'h7, 0, 0, 0,   1, 5'h03, 3, 8'd1, 0);
    vecs[5]  = mk(1, 4'h9, 0, 0, 0,   1, 5'h03, 4, 8'd1, 0); // full
    vecs[6]  = mk(1, 4'hB, 1, 0, 0,   1, 5'h03, 4, 8'd1, 1); // dropped, carry not counted
    vecs[7]  = mk(1, 4'hC, 0, 1, 1,   1, 5'h05, 4, 8'd1, 0); // full push+pop, ovf cleared
    vecs[8]  = mk(1, 4'hD, 0, 0, 1,   1, 5'h05, 4, 8'd1, 1); // drop with clear: set wins
    vecs[9]  = mk(0, 4'h0, 0, 0, 1,   1, 5'h05, 4, 8'd1, 0); // clear only
    vecs[10] = mk(0, 4'h0, 0, 1, 0,   1, 5'h07, 3, 8'd1, 0);
    vecs[11] = mk(0, 4'h0, 0, 1, 0,   1, 5'h09, 2, 8'd1, 0);
    vecs[12] = mk(0, 4'h0, 0, 1, 0,   1, 5'h0C, 1, 8'd1, 0);
    vecs[13] = mk(0, 4'h0, 0, 1, 0,   0, 5'h00, 0, 8'd1, 0);
    vecs[14] = mk(0, 4'h0, 0, 1, 0,   0, 5'h00, 0, 8'd1, 0); // ready on empty: no effect
    vecs[15] = mk(1, 4'h1, 0, 1, 0,   1, 5'h01, 1, 8'd1, 0); // empty push+ready: push only
    vecs[16] = mk(1, 4'h2, 1, 1, 0,   1, 5'h12, 1, 8'd2, 0); // push+pop at level 1
    vecs[17] = mk(0, 4'h0, 0, 1, 0,   0, 5'h00, 0, 8'd2, 0);

    rst_n = 1'b0; in_valid = 1'b0; in_sum = '0; in_carry = 1'b0;
    out_ready = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(negedge clk);
    check_outs("reset", 1'b0, 5'h00, 3'd0, 8'd0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      in_valid  = vecs[i].iv;
      in_sum    = vecs[i].sum;
      in_carry  = vecs[i].ic;
      out_ready = vecs[i].rdy;
      ovf_clr   = vecs[i].clr;
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].el, vecs[i].ec, vecs[i].eo);
    end

    // Continuous push+pop stream with carry=1: count saturates, head follows input.
    ovf_clr = 1'b0;
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'b1;
      in_sum    = 4'(i);
      in_carry  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      if ((i % 50) == 0 || i == 299) begin
        check($sformatf("stream%0d.out_data", i), {27'd0, out_data}, {27'd0, 1'b1, 4'(i)});
        check($sformatf("stream%0d.level", i), {29'd0, level}, 32'd1);
      end
    end
    check("stream.carry_cnt_sat", {24'd0, carry_cnt}, 32'd255);

    // Asynchronous reset between edges while traffic is still flowing.
    #2 rst_n = 1'b0;
    #1;
    check_outs("midreset", 1'b0, 5'h00, 3'd0, 8'd0, 1'b0);
    @(negedge clk);
    rst_n     = 1'b1;
    in_valid  = 1'b1;
    in_sum    = 4'h6;
    in_carry  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check_outs("post_reset_push", 1'b1, 5'h06, 3'd1, 8'd0, 1'b0);
    in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_result_collector.md
ADDER_RESULT_COLLECTOR -- requirements
Module: adder_result_collector

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning operand/sum width of the upstream adder.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning result FIFO entries (power of two, >=2).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid  input  1  adder result present this cycle.
REQ-006 The block SHALL have port in_sum  input  N  adder sum.
REQ-007 The block SHALL have port in_carry  input  1  adder carry-out.
REQ-008 The block SHALL have port out_valid  output  1  head entry available.
REQ-009 The block SHALL have port out_ready  input  1  consumer accepts head entry.
REQ-010 The block SHALL have port out_data  output  N+1  head entry {carry, sum}.
REQ-011 The block SHALL have port level  output  $clog2(DEPTH)+1  entries held.
REQ-012 The block SHALL have port carry_cnt  output  8  count of accepted results with carry=1.
REQ-013 The block SHALL have port ovf  output  1  sticky drop flag.
REQ-014 The block SHALL have port ovf_clr  input  1  clears ovf.

Function
REQ-015 Push: in_valid=1 and (level<DEPTH or pop this cycle) SHALL write {in_carry,in_sum} at the tail.
REQ-016 Pop: out_valid=1 and out_ready=1 SHALL retire the head entry.
REQ-017 out_valid SHALL equal (level!=0); out_data SHALL be the head entry when out_valid=1, else all zeros.
REQ-018 Latency: a result pushed at edge k SHALL be visible on out_data/out_valid after edge k (zero-wait when empty), no combinational in->out path.
REQ-019 Ordering SHALL be strict first-in first-out.
REQ-020 Pointers SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full = MSBs differ, lower bits equal; empty = pointers equal.
REQ-021 level SHALL update +1 on push-only, -1 on pop-only, unchanged on simultaneous push+pop or neither.
REQ-022 Full with simultaneous push+pop SHALL accept the push; level stays DEPTH.
REQ-023 Empty with in_valid=1 and out_ready=1 SHALL push only (no pop of empty FIFO); level becomes 1.
REQ-024 in_valid=1 while full and no pop SHALL drop the result, leave FIFO and carry_cnt unchanged, and set ovf=1.
REQ-025 ovf_clr=1 SHALL clear ovf next edge; if a drop occurs the same cycle, ovf SHALL remain 1 (set wins).
REQ-026 carry_cnt SHALL increment on each accepted push with in_carry=1 and saturate at 255.
REQ-027 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-028 rst_n=0 SHALL asynchronously force pointers, level, carry_cnt, ovf to 0; out_valid=0, out_data=0.
REQ-029 Reset asserted mid-stream SHALL discard all stored entries; storage array contents need not be cleared.
REQ-030 First push SHALL be accepted on the first posedge after rst_n deasserts.

Configuration
REQ-031 With ADDER_RESULT_PARITY_EN defined, the block SHALL add output out_parity (1 bit) = XOR of all out_data bits, 0 when empty.
REQ-032 Without ADDER_RESULT_PARITY_EN, out_parity SHALL not exist and behaviour SHALL be otherwise identical.

Verification
REQ-033 Reset, push sum=4'hA carry=1, out_ready=0 -> next cycle out_valid=1, out_data=5'h1A, level=1, carry_cnt=1.
REQ-034 Push 4 results (3,5,7,9, carry=0) with out_ready=0, then 5th push -> level=4, ovf=1, 5th dropped; drain yields 3,5,7,9 in order.
REQ-035 Full FIFO, in_valid=1 and out_ready=1 same cycle -> head retired, new entry appended, level=4, ovf=0.
REQ-036 Empty FIFO, in_valid=1 sum=1, out_ready=1 -> level=1, out_data=5'h01 next cycle.
REQ-037 300 pushes with carry=1 while draining continuously -> carry_cnt=255; assert rst_n=0 mid-stream -> all outputs 0 immediately.
REQ-038 With ADDER_RESULT_PARITY_EN, head 5'h1A -> out_parity=1; head 5'h03 -> out_parity=0.
